// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store controller with req/gnt/rvalid memory handshake
//
// Purpose:
//   Accepts one core load/store at a time, decodes byte enables and lane-shifted
//   store data, runs the memory request/grant/response handshake, and returns
//   sign/zero-extended load data. Misaligned accesses, illegal funct3 values and
//   memory timeouts are reported as error responses and never reach memory.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           core request handshake (ready only in IDLE)
//   req_write, req_f3             store/load select and RISC-V funct3
//   req_addr, req_wdata           byte address and right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err one-cycle response pulse, data, error code
//   mem_req/mem_gnt               memory request handshake
//   mem_we, mem_addr, mem_be      write strobe, word address, byte enables
//   mem_wdata                     lane-shifted store data
//   mem_rvalid, mem_rdata         memory completion and raw read word

module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;

    // Request decode, evaluated on the raw request while in IDLE.
    logic [1:0]  dec_off;
    logic [3:0]  dec_be;
    logic        dec_misaligned;
    logic        dec_illegal;
    logic [31:0] dec_wdata;

    always_comb begin
        dec_off        = req_addr[1:0];
        dec_be         = 4'b0000;
        dec_misaligned = 1'b0;
        case (req_f3[1:0])
            2'b00: dec_be = 4'b0001 << dec_off;
            2'b01: begin
                dec_be         = dec_off[1] ? 4'b1100 : 4'b0011;
                dec_misaligned = dec_off[0];
            end
            2'b10: begin
                dec_be         = 4'b1111;
                dec_misaligned = (dec_off != 2'b00);
            end
            default: dec_be = 4'b0000;
        endcase
        // Stores only have SB/SH/SW; loads additionally allow LBU/LHU.
        if (req_write) begin
            dec_illegal = req_f3[2] | (req_f3[1:0] == 2'b11);
        end else begin
            dec_illegal = (req_f3 == 3'b011) | (req_f3 == 3'b110) | (req_f3 == 3'b111);
        end
        dec_wdata = req_wdata << {dec_off, 3'b000};
    end

    // Load extraction from the raw word using the latched funct3 and offset.
    logic [31:0] ld_shifted;
    logic [31:0] ld_data;

    always_comb begin
        ld_shifted = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b100:  ld_data = {24'h0, ld_shifted[7:0]};
            3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b101:  ld_data = {16'h0, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    logic [7:0] cnt_inc;
    logic       timed_out;

    always_comb begin
        cnt_inc   = cnt_q + 8'd1;
        timed_out = (cnt_inc == TIMEOUT_LIMIT);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_write;
                    be_d    = dec_be;
                    addr_d  = {req_addr[31:2], 2'b00};
                    wdata_d = dec_wdata;
                    f3_d    = req_f3;
                    off_d   = dec_off;
                    rdata_d = 32'h0;
                    cnt_d   = 8'd0;
                    // Illegal funct3 is checked first so it wins over misalignment.
                    if (dec_illegal) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = S_RESP;
                    end else if (dec_misaligned) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_RESP;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_inc;
                if (timed_out) begin
                    err_d   = ERR_TIMEOUT;
                    rdata_d = 32'h0;
                    state_d = S_RESP;
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // The budget expiring overrides a response arriving in the same cycle.
                if (timed_out) begin
                    err_d   = ERR_TIMEOUT;
                    rdata_d = 32'h0;
                    state_d = S_RESP;
                end else if (mem_rvalid) begin
                    rdata_d = we_q ? 32'h0 : ld_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            rdata_q <= 32'h0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs are registered fields gated by state, so memory-side signals
    // are zero outside ISSUE and response fields are zero outside RESP.
    logic in_issue;
    logic in_resp;

    assign in_issue  = (state_q == S_ISSUE);
    assign in_resp   = (state_q == S_RESP);

    assign req_ready = (state_q == S_IDLE);
    assign mem_req   = in_issue;
    assign mem_we    = in_issue & we_q;
    assign mem_be    = in_issue ? be_q : 4'b0000;
    assign mem_addr  = in_issue ? addr_q : 32'h0;
    assign mem_wdata = in_issue ? wdata_q : 32'h0;
    assign rsp_valid = in_resp;
    assign rsp_rdata = in_resp ? rdata_q : 32'h0;
    assign rsp_err   = in_resp ? err_q : ERR_OK;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc = 0;

    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_f3     (req_f3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: records every response pulse for the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) obs_q.push_back({rsp_rdata, rsp_err});
    end

    // Drive one request from a negedge; returns at the negedge after acceptance.
    task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        req_valid = 1'b1;
        req_write = w;
        req_f3    = f3;
        req_addr  = a;
        req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc = cyc;
    endtask

    // Immediate grant, response on the following cycle; returns at the RESP negedge.
    task automatic mem_ok(input logic [31:0] rd);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_rsp: ready=%0b valid=%0b rdata=%h err=%b required 1 0 0 00",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        n_cmp++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'h0) begin
            n_bad++;
            $display("FAIL reset_mem: req=%0b we=%0b be=%b addr=%h wdata=%h required all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_word;
        exp_q.push_back({32'h0, 2'b00});
        send(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        n_cmp++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid} !==
            {1'b1, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 1'b0}) begin
            n_bad++;
            $display("FAIL sw_issue: req=%0b we=%0b be=%b addr=%h wdata=%h rsp=%0b required 1 1 1111 100 deadbeef 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        n_cmp++;
        if ({mem_req, mem_be, mem_we} !== 6'b0) begin
            n_bad++;
            $display("FAIL sw_wait_idle_bus: req=%0b be=%b we=%0b required 0", mem_req, mem_be, mem_we);
        end
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || cyc - acc != 2) begin
            n_bad++;
            $display("FAIL sw_latency: rsp_valid=%0b at %0d cycles after accept, required 1 at 3",
                     rsp_valid, cyc - acc + 1);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL sw_pulse: rsp_valid=%0b ready=%0b required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_store_narrow;
        exp_q.push_back({32'h0, 2'b00});
        send(1'b1, 3'b000, 32'h203, 32'h000000A5);
        n_cmp++;
        if ({mem_be, mem_addr, mem_wdata[31:24], mem_we} !== {4'b1000, 32'h200, 8'hA5, 1'b1}) begin
            n_bad++;
            $display("FAIL sb_lane: be=%b addr=%h byte3=%h we=%0b required 1000 200 a5 1",
                     mem_be, mem_addr, mem_wdata[31:24], mem_we);
        end
        mem_ok(32'h0);
        @(negedge clk);
        exp_q.push_back({32'h0, 2'b00});
        send(1'b1, 3'b001, 32'h202, 32'h00001234);
        n_cmp++;
        if ({mem_be, mem_addr, mem_wdata[31:16]} !== {4'b1100, 32'h200, 16'h1234}) begin
            n_bad++;
            $display("FAIL sh_lane: be=%b addr=%h half=%h required 1100 200 1234",
                     mem_be, mem_addr, mem_wdata[31:16]);
        end
        mem_ok(32'h0);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rd;
        logic [31:0] exp;
        logic [3:0]  be;
    } ld_t;

    task automatic test_loads;
        ld_t lt [6];
        lt[0] = '{3'b000, 32'h301, 32'h00008000, 32'hFFFFFF80, 4'b0010};
        lt[1] = '{3'b100, 32'h301, 32'h00008000, 32'h00000080, 4'b0010};
        lt[2] = '{3'b001, 32'h302, 32'h80010000, 32'hFFFF8001, 4'b1100};
        lt[3] = '{3'b101, 32'h302, 32'h80010000, 32'h00008001, 4'b1100};
        lt[4] = '{3'b010, 32'h104, 32'h12345678, 32'h12345678, 4'b1111};
        lt[5] = '{3'b000, 32'h300, 32'h0000007F, 32'h0000007F, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({lt[i].exp, 2'b00});
            send(1'b0, lt[i].f3, lt[i].addr, 32'hFFFFFFFF);
            n_cmp++;
            if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, lt[i].be, lt[i].addr & 32'hFFFFFFFC}) begin
                n_bad++;
                $display("FAIL load_issue[%0d]: req=%0b we=%0b be=%b addr=%h required 1 0 %b %h",
                         i, mem_req, mem_we, mem_be, mem_addr, lt[i].be, lt[i].addr & 32'hFFFFFFFC);
            end
            mem_ok(lt[i].rd);
            @(negedge clk);
        end
    endtask

    task automatic test_errors;
        logic [37:0] et [5];
        et[0] = {1'b0, 3'b010, 32'h101, 2'b01};
        et[1] = {1'b0, 3'b011, 32'h100, 2'b10};
        et[2] = {1'b1, 3'b100, 32'h101, 2'b10};
        et[3] = {1'b0, 3'b001, 32'h303, 2'b01};
        et[4] = {1'b1, 3'b011, 32'h100, 2'b10};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({32'h0, et[i][1:0]});
            send(et[i][37], et[i][36:34], et[i][33:2], 32'h55AA55AA);
            n_cmp++;
            if (rsp_valid !== 1'b1 || mem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL err_fast[%0d]: rsp_valid=%0b mem_req=%0b required 1 0", i, rsp_valid, mem_req);
            end
            @(negedge clk);
            n_cmp++;
            if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL err_no_mem[%0d]: mem_req=%0b rsp_valid=%0b required 0 0", i, mem_req, rsp_valid);
            end
        end
    endtask

    task automatic test_timeout;
        int reqs;
        bit seen;
        exp_q.push_back({32'h0, 2'b11});
        send(1'b0, 3'b010, 32'h400, 32'h0);
        reqs = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (mem_req) reqs++;
            @(negedge clk);
        end
        n_cmp++;
        if (!seen || reqs != 4) begin
            n_bad++;
            $display("FAIL timeout_len: rsp_seen=%0b mem_req_cycles=%0d required 1 4", seen, reqs);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBADBAD00;
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL late_rvalid: rsp_valid=%0b ready=%0b mem_req=%0b required 0 1 0",
                     rsp_valid, req_ready, mem_req);
        end
        exp_q.push_back({32'hCAFEF00D, 2'b00});
        send(1'b0, 3'b010, 32'h404, 32'h0);
        mem_ok(32'hCAFEF00D);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL after_timeout: rsp_valid=%0b required 1", rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        exp_q.push_back({32'h0, 2'b00});
        send(1'b0, 3'b010, 32'h500, 32'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_busy: req_ready=%0b required 0", req_ready);
        end
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        n_cmp++;
        if ({mem_req, rsp_valid, mem_be, req_ready} !== {1'b0, 1'b0, 4'b0000, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset: mem_req=%0b rsp_valid=%0b be=%b ready=%0b required 0 0 0000 1",
                     mem_req, rsp_valid, mem_be, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back({32'h11223344, 2'b00});
        send(1'b0, 3'b010, 32'h504, 32'h0);
        mem_ok(32'h11223344);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int t1;
        exp_q.push_back({32'hFFFFFFA0, 2'b00});
        exp_q.push_back({32'h0000A0A0, 2'b00});
        send(1'b0, 3'b000, 32'h600, 32'h0);
        mem_ok(32'h000000A0);
        t1 = cyc;
        send(1'b0, 3'b101, 32'h602, 32'h0);
        mem_ok(32'hA0A00000);
        n_cmp++;
        if (rsp_valid !== 1'b1 || cyc - t1 != 4) begin
            n_bad++;
            $display("FAIL b2b_period: rsp_valid=%0b period=%0d required 1 4", rsp_valid, cyc - t1);
        end
        @(negedge clk);
    endtask

    task automatic test_scoreboard;
        logic [33:0] e;
        logic [33:0] o;
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL rsp_count: observed=%0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rsp_data: rdata=%h err=%b required rdata=%h err=%b",
                         o[33:2], o[1:0], e[33:2], e[1:0]);
            end
        end
    endtask

    initial begin
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_f3     = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        rst_n      = 1'b0;
        @(negedge clk);
        test_reset;
        test_store_word;
        test_store_narrow;
        test_loads;
        test_errors;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        repeat (2) @(negedge clk);
        test_scoreboard;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
